issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 8, entry count; a power of two, at least 4.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port flush  input  1  synchronous queue clear (branch mispredict/exception).
REQ-005 The block SHALL have port i_set1  input  PC_set  decoded older instruction from decode.
REQ-006 The block SHALL have port i_set2  input  PC_set  decoded younger instruction from decode.
REQ-007 The block SHALL have port i_valid  input  2  enqueue request; [1] = i_set1 valid, [0] = i_set2 valid.
REQ-008 The block SHALL have port o_ready  output  1  high when at least 2 entries are free.
REQ-009 The block SHALL have port o_set1  output  PC_set  head entry, the oldest instruction.
REQ-010 The block SHALL have port o_set2  output  PC_set  entry at head+1.
REQ-011 The block SHALL have port o_is_valid  output  2  [1] = o_set1 valid, [0] = o_set2 valid.
REQ-012 The block SHALL have port i_usingNUM  input  2  number of entries consumed by dispatch this cycle (0, 1 or 2).

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH PC_set entries, with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count register of log2(DEPTH)+1 bits.
REQ-014 o_set1, o_set2 and o_is_valid SHALL be driven only from registered state (entries, head, count) and SHALL have no combinational path from i_usingNUM, so the loop through dispatch stays broken.
REQ-015 o_set1 SHALL equal mem[head] and o_set2 SHALL equal mem[(head+1) mod DEPTH].
REQ-016 o_is_valid[1] SHALL equal count>=1; o_is_valid[0] SHALL equal count>=2.
REQ-017 The o_valid fields of o_set1/o_set2 SHALL mirror o_is_valid[1]/[0].
REQ-018 o_ready SHALL equal (DEPTH - count) >= 2, computed from the current count with no credit for a same-cycle dequeue.
REQ-019 Enqueue SHALL occur only when o_ready=1 and flush=0; otherwise all of i_valid SHALL be ignored and nothing written.
REQ-020 Enqueue with i_valid=2'b11 SHALL write i_set1 at tail and i_set2 at tail+1, then advance tail by 2.
REQ-021 Enqueue with i_valid=2'b10 SHALL write i_set1 at tail and advance tail by 1.
REQ-022 Enqueue with i_valid=2'b01 SHALL write i_set2 at tail and advance tail by 1.
REQ-023 Dequeue count SHALL be n_deq = min(i_usingNUM, count); i_usingNUM=3 SHALL be treated as 0; head SHALL advance by n_deq.
REQ-024 Enqueue and dequeue in the same cycle SHALL both take effect: count_next = count + n_enq - n_deq.
REQ-025 Enqueue on an empty queue SHALL appear on the outputs the next cycle, giving 1-cycle enqueue-to-visible latency; there is no bypass.
REQ-026 flush=1 SHALL, at the next edge, set head=tail=count=0, overriding any same-cycle enqueue and dequeue.
REQ-027 Entry contents SHALL persist until overwritten; o_set1/o_set2 contents while invalid are don't-care.

Reset
REQ-028 While rstn=0, head, tail and count SHALL be 0, o_is_valid SHALL be 2'b00 and o_ready SHALL be 1, all asynchronously.
REQ-029 Entry storage SHALL NOT be reset.
REQ-030 Reset deassertion mid-operation SHALL leave the queue empty with the first enqueue accepted on the first edge after release.

Verification
REQ-031 Reset, then enqueue 2'b11 (PC 0x1c000000 / 0x1c000004) with i_usingNUM=0 -> next cycle o_is_valid=2'b11, o_set1.PC=0x1c000000, o_set2.PC=0x1c000004.
REQ-032 Fill DEPTH=8 with 3 pairs (count=6), then enqueue a pair -> count=8, o_ready=0; a further 2'b11 with i_usingNUM=0 -> no write, count stays 8.
REQ-033 count=7 with o_ready=0, enqueue 2'b11 plus i_usingNUM=2 -> enqueue dropped, count=5; the oldest two PCs are removed in order.
REQ-034 Wrap: head=tail=6, count=0; enqueue pairs to count=4 -> o_set2 of entry 7 followed by entry 0 in order, with PC order preserved across the wrap.
REQ-035 count=1, i_usingNUM=2 -> count=0, o_is_valid=2'b00 (clamped); with i_usingNUM=3 -> count unchanged.
REQ-036 count=5 with flush=1, enqueue 2'b11 and i_usingNUM=1 in the same cycle -> next cycle count=0, o_is_valid=2'b00, o_ready=1.

Source files
------------

// File: rtl/issue_queue.sv
// issue_queue: dual-enqueue, dual-dequeue circular issue queue between decode and dispatch.
typedef struct packed {
  logic        o_valid;
  logic [31:0] PC;
  logic [31:0] inst;
} PC_set;

module issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush,
  input  PC_set      i_set1,
  input  PC_set      i_set2,
  input  logic [1:0] i_valid,
  output logic       o_ready,
  output PC_set      o_set1,
  output PC_set      o_set2,
  output logic [1:0] o_is_valid,
  input  logic [1:0] i_usingNUM
);
  localparam int AW = $clog2(DEPTH);
  PC_set          r_mem [DEPTH];
  logic [AW-1:0]  r_head, r_tail;
  logic [AW:0]    r_count;
  logic [AW:0]    w_free;
  logic           w_en;
  logic [1:0]     w_nenq, w_req, w_ndeq;
  assign w_free = (AW+1)'(DEPTH) - r_count;
  assign o_ready = w_free >= (AW+1)'(2);
  assign w_en = o_ready & ~flush;
  assign w_nenq = w_en ? {1'b0, i_valid[1]} + {1'b0, i_valid[0]} : 2'd0;
  assign w_req = (i_usingNUM == 2'd3) ? 2'd0 : i_usingNUM;
  assign w_ndeq = (r_count < (AW+1)'(w_req)) ? r_count[1:0] : w_req;
  assign o_is_valid = {r_count >= (AW+1)'(1), r_count >= (AW+1)'(2)};
  // Outputs come from registered state only; dispatch's consume count never reaches them.
  always_comb begin
    o_set1 = r_mem[r_head];
    o_set2 = r_mem[r_head + AW'(1)];
    o_set1.o_valid = o_is_valid[1];
    o_set2.o_valid = o_is_valid[0];
  end
  always_ff @(posedge clk) begin
    if (w_en & i_valid[1]) r_mem[r_tail] <= i_set1;
    if (w_en & i_valid[0]) r_mem[r_tail + AW'(i_valid[1])] <= i_set2;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_ndeq);
      r_tail  <= r_tail + AW'(w_nenq);
      r_count <= r_count + (AW+1)'(w_nenq) - (AW+1)'(w_ndeq);
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed per-cycle vector table plus async-reset sequences for issue_queue.
module tb_issue_queue;
  logic        clk = 0, rstn = 0, flush = 0;
  logic [64:0] set1 = '0, set2 = '0, o1, o2;
  logic [1:0]  valid = 0, using_num = 0, is_valid;
  logic        ready;
  int          n_chk = 0, n_pass = 0;

  typedef struct {
    logic        fl;
    logic [1:0]  v;
    logic [31:0] p1, p2;
    logic [1:0]  u;
    logic [1:0]  ev;
    logic        er;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t tv[24];

  issue_queue #(.DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .i_set1(set1), .i_set2(set2), .i_valid(valid),
    .o_ready(ready), .o_set1(o1), .o_set2(o2),
    .o_is_valid(is_valid), .i_usingNUM(using_num)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic fl, logic [1:0] v, logic [31:0] p1, logic [31:0] p2,
                              logic [1:0] u, logic [1:0] ev, logic er,
                              logic [31:0] e1, logic [31:0] e2);
    mk = '{fl, v, p1, p2, u, ev, er, e1, e2};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(logic fl, logic [1:0] v, logic [31:0] p1, logic [31:0] p2, logic [1:0] u);
    flush = fl;
    valid = v;
    using_num = u;
    set1 = {1'b0, p1, ~p1};
    set2 = {1'b0, p2, ~p2};
  endtask

  task automatic check_out(string tag, logic [1:0] ev, logic er, logic [31:0] e1, logic [31:0] e2);
    chk({tag, " is_valid"}, 32'(is_valid), 32'(ev));
    chk({tag, " ready"}, 32'(ready), 32'(er));
    chk({tag, " set1.o_valid"}, 32'(o1[64]), 32'(ev[1]));
    chk({tag, " set2.o_valid"}, 32'(o2[64]), 32'(ev[0]));
    if (ev[1]) chk({tag, " set1.PC"}, o1[63:32], e1);
    if (ev[1]) chk({tag, " set1.inst"}, o1[31:0], ~e1);
    if (ev[0]) chk({tag, " set2.PC"}, o2[63:32], e2);
  endtask

  initial begin
    tv[0]  = mk(0, 2'b11, 32'h1c000000, 32'h1c000004, 0, 2'b11, 1, 32'h1c000000, 32'h1c000004);
    tv[1]  = mk(0, 2'b11, 32'h1c000008, 32'h1c00000c, 0, 2'b11, 1, 32'h1c000000, 32'h1c000004);
    tv[2]  = mk(0, 2'b11, 32'h1c000010, 32'h1c000014, 0, 2'b11, 1, 32'h1c000000, 32'h1c000004);
    tv[3]  = mk(0, 2'b11, 32'h1c000018, 32'h1c00001c, 0, 2'b11, 0, 32'h1c000000, 32'h1c000004);
    tv[4]  = mk(0, 2'b11, 32'h1c000020, 32'h1c000024, 0, 2'b11, 0, 32'h1c000000, 32'h1c000004);
    tv[5]  = mk(0, 2'b00, 0, 0, 1, 2'b11, 0, 32'h1c000004, 32'h1c000008);
    tv[6]  = mk(0, 2'b11, 32'h1c000028, 32'h1c00002c, 2, 2'b11, 1, 32'h1c00000c, 32'h1c000010);
    tv[7]  = mk(0, 2'b00, 0, 0, 2, 2'b11, 1, 32'h1c000014, 32'h1c000018);
    tv[8]  = mk(0, 2'b00, 0, 0, 2, 2'b10, 1, 32'h1c00001c, 0);
    tv[9]  = mk(0, 2'b00, 0, 0, 3, 2'b10, 1, 32'h1c00001c, 0);
    tv[10] = mk(0, 2'b00, 0, 0, 2, 2'b00, 1, 0, 0);
    tv[11] = mk(0, 2'b11, 32'h1c000030, 32'h1c000034, 0, 2'b11, 1, 32'h1c000030, 32'h1c000034);
    tv[12] = mk(0, 2'b11, 32'h1c000038, 32'h1c00003c, 2, 2'b11, 1, 32'h1c000038, 32'h1c00003c);
    tv[13] = mk(0, 2'b10, 32'h1c000040, 32'h1c0000ff, 2, 2'b10, 1, 32'h1c000040, 0);
    tv[14] = mk(0, 2'b01, 32'h1c0000ee, 32'h1c000044, 1, 2'b10, 1, 32'h1c000044, 0);
    tv[15] = mk(0, 2'b00, 0, 0, 1, 2'b00, 1, 0, 0);
    tv[16] = mk(0, 2'b11, 32'h1c000050, 32'h1c000054, 0, 2'b11, 1, 32'h1c000050, 32'h1c000054);
    tv[17] = mk(0, 2'b11, 32'h1c000058, 32'h1c00005c, 0, 2'b11, 1, 32'h1c000050, 32'h1c000054);
    tv[18] = mk(0, 2'b00, 0, 0, 1, 2'b11, 1, 32'h1c000054, 32'h1c000058);
    tv[19] = mk(0, 2'b00, 0, 0, 2, 2'b10, 1, 32'h1c00005c, 0);
    tv[20] = mk(0, 2'b11, 32'h1c000060, 32'h1c000064, 0, 2'b11, 1, 32'h1c00005c, 32'h1c000060);
    tv[21] = mk(0, 2'b11, 32'h1c000068, 32'h1c00006c, 0, 2'b11, 1, 32'h1c00005c, 32'h1c000060);
    tv[22] = mk(1, 2'b11, 32'h1c000070, 32'h1c000074, 1, 2'b00, 1, 0, 0);
    tv[23] = mk(0, 2'b11, 32'h1c000078, 32'h1c00007c, 0, 2'b11, 1, 32'h1c000078, 32'h1c00007c);

    #1;
    check_out("reset", 2'b00, 1, 0, 0);
    repeat (2) @(posedge clk);
    #2 rstn = 1;
    for (int i = 0; i < 24; i++) begin
      drive(tv[i].fl, tv[i].v, tv[i].p1, tv[i].p2, tv[i].u);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), tv[i].ev, tv[i].er, tv[i].e1, tv[i].e2);
    end

    // Fill to full (count 2 -> 8), then reset asynchronously with no clock edge.
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'b11, 32'h1c000100 + 32'(8 * i), 32'h1c000104 + 32'(8 * i), 0);
      @(posedge clk);
      #1;
    end
    check_out("full", 2'b11, 0, 32'h1c000078, 32'h1c00007c);
    drive(0, 2'b00, 0, 0, 0);
    #2 rstn = 0;
    #1;
    check_out("async_rst", 2'b00, 1, 0, 0);
    @(negedge clk);
    rstn = 1;
    drive(0, 2'b11, 32'h1c000080, 32'h1c000084, 1);
    @(posedge clk);
    #1;
    check_out("post_rst", 2'b11, 1, 32'h1c000080, 32'h1c000084);
    drive(0, 2'b00, 0, 0, 0);
    @(posedge clk);
    #1;
    check_out("hold", 2'b11, 1, 32'h1c000080, 32'h1c000084);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
